load_store_unit: RTL and testbench

Memory-access stage of the RV32E pipeline, directly downstream of the EX→MEMPREP pipeline register. Takes the ALU result as the effective address, performs loads/stores over a single-outstanding request/grant/response data bus, and aligns load data. It produces the registered write-back bundle for the MEM stage. While a bus transaction is in flight it stalls the upstream pipeline.

---
 rtl/core_pkg.sv | 47 ++++
 rtl/load_data_aligner.sv | 32 +++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared load/store definitions: access-size encodings, LSU state type,
// byte strobe type and the pure helper functions used by the MEM stage.
package core_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2
    } lsu_state_t;

    typedef logic [3:0] strobe_t;

    // Misaligned half/word or an encoding with no defined access size.
    function automatic logic access_fault(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            LS_B, LS_BU: access_fault = 1'b0;
            LS_H, LS_HU: access_fault = addr_lo[0];
            LS_W:        access_fault = (addr_lo != 2'b00);
            default:     access_fault = 1'b1;
        endcase
    endfunction

    // Byte lanes touched by a store; size comes from the low funct3 bits.
    function automatic strobe_t store_strobe(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3[1:0])
            2'b00:   store_strobe = strobe_t'(4'b0001 << addr_lo);
            2'b01:   store_strobe = strobe_t'(4'b0011 << addr_lo);
            default: store_strobe = 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate their data across all lanes so the strobe alone picks the lane.
    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   store_wdata = {4{data[7:0]}};
            2'b01:   store_wdata = {2{data[15:0]}};
            default: store_wdata = data;
        endcase
    endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Picks the addressed byte/half out of a load response word and extends it.
module load_data_aligner
    import core_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection followed by sign/zero extension by access type.
    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LS_B:    result = {{24{byte_sel[7]}}, byte_sel};
            LS_BU:   result = {24'b0, byte_sel};
            LS_H:    result = {{16{half_sel[15]}}, half_sel};
            LS_HU:   result = {16'b0, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM stage of the RV32E pipeline: single-outstanding data bus master with
// registered write-back bundle; stalls upstream while a transaction is open.
module load_store_unit
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_MEMPREP,
    input  logic        mem_read_MEMPREP,
    input  logic        mem_write_MEMPREP,
    input  logic [2:0]  funct3_MEMPREP,
    input  logic [31:0] alu_result_MEMPREP,
    input  logic [31:0] store_data_MEMPREP,
    input  logic [3:0]  rd_MEMPREP,
    input  logic        regfile_we_MEMPREP,
    output logic        stall,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output strobe_t     dbus_wstrb,
    input  logic        dbus_gnt,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic        valid_MEM,
    output logic [31:0] result_MEM,
    output logic [3:0]  rd_MEM,
    output logic        regfile_we_MEM,
    output logic        mem_fault_MEM
);

    lsu_state_t  state;
    logic [1:0]  cap_addr_lo;
    logic [2:0]  cap_funct3;
    logic [3:0]  cap_rd;
    logic        cap_we;
    logic        cap_store;
    logic        is_mem;
    logic        fault;
    logic [31:0] load_result;

    assign stall  = (state != IDLE);
    assign is_mem = valid_MEMPREP & (mem_read_MEMPREP | mem_write_MEMPREP);
    assign fault  = access_fault(funct3_MEMPREP, alu_result_MEMPREP[1:0]);

    load_data_aligner u_aligner (
        .rdata  (dbus_rdata),
        .addr   (cap_addr_lo),
        .funct3 (cap_funct3),
        .result (load_result)
    );

    // Sequencer plus registered bus and write-back outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cap_addr_lo    <= '0;
            cap_funct3     <= '0;
            cap_rd         <= '0;
            cap_we         <= 1'b0;
            cap_store      <= 1'b0;
            dbus_req       <= 1'b0;
            dbus_we        <= 1'b0;
            dbus_addr      <= '0;
            dbus_wdata     <= '0;
            dbus_wstrb     <= '0;
            valid_MEM      <= 1'b0;
            result_MEM     <= '0;
            rd_MEM         <= '0;
            regfile_we_MEM <= 1'b0;
            mem_fault_MEM  <= 1'b0;
        end else begin
            // Completion pulses; overridden below only on a completing edge.
            valid_MEM      <= 1'b0;
            regfile_we_MEM <= 1'b0;
            mem_fault_MEM  <= 1'b0;
            case (state)
                IDLE: begin
                    if (is_mem && fault) begin
                        valid_MEM     <= 1'b1;
                        mem_fault_MEM <= 1'b1;
                        result_MEM    <= alu_result_MEMPREP;
                        rd_MEM        <= rd_MEMPREP;
                    end else if (is_mem) begin
                        state       <= REQ;
                        cap_addr_lo <= alu_result_MEMPREP[1:0];
                        cap_funct3  <= funct3_MEMPREP;
                        cap_rd      <= rd_MEMPREP;
                        cap_we      <= regfile_we_MEMPREP;
                        cap_store   <= mem_write_MEMPREP;
                        dbus_req    <= 1'b1;
                        dbus_we     <= mem_write_MEMPREP;
                        dbus_addr   <= {alu_result_MEMPREP[31:2], 2'b00};
                        dbus_wdata  <= mem_write_MEMPREP ?
                                       store_wdata(funct3_MEMPREP, store_data_MEMPREP) : 32'b0;
                        dbus_wstrb  <= mem_write_MEMPREP ?
                                       store_strobe(funct3_MEMPREP, alu_result_MEMPREP[1:0]) : 4'b0000;
                    end else begin
                        valid_MEM      <= valid_MEMPREP;
                        result_MEM     <= alu_result_MEMPREP;
                        rd_MEM         <= rd_MEMPREP;
                        regfile_we_MEM <= valid_MEMPREP & regfile_we_MEMPREP;
                    end
                end
                REQ: begin
                    if (dbus_gnt) begin
                        dbus_req <= 1'b0;
                        if (cap_store) begin
                            state     <= IDLE;
                            valid_MEM <= 1'b1;
                            rd_MEM    <= cap_rd;
                        end else begin
                            state <= WAIT_RESP;
                        end
                    end
                end
                WAIT_RESP: begin
                    if (dbus_rvalid) begin
                        state          <= IDLE;
                        valid_MEM      <= 1'b1;
                        result_MEM     <= load_result;
                        rd_MEM         <= cap_rd;
                        regfile_we_MEM <= cap_we;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_MEMPREP, mem_read_MEMPREP, mem_write_MEMPREP;
    logic [2:0]  funct3_MEMPREP;
    logic [31:0] alu_result_MEMPREP, store_data_MEMPREP;
    logic [3:0]  rd_MEMPREP;
    logic        regfile_we_MEMPREP;
    logic        stall, dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata;
    logic [3:0]  dbus_wstrb;
    logic        dbus_gnt, dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        valid_MEM;
    logic [31:0] result_MEM;
    logic [3:0]  rd_MEM;
    logic        regfile_we_MEM, mem_fault_MEM;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .valid_MEMPREP(valid_MEMPREP), .mem_read_MEMPREP(mem_read_MEMPREP),
        .mem_write_MEMPREP(mem_write_MEMPREP), .funct3_MEMPREP(funct3_MEMPREP),
        .alu_result_MEMPREP(alu_result_MEMPREP), .store_data_MEMPREP(store_data_MEMPREP),
        .rd_MEMPREP(rd_MEMPREP), .regfile_we_MEMPREP(regfile_we_MEMPREP),
        .stall(stall), .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_gnt(dbus_gnt),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
        .valid_MEM(valid_MEM), .result_MEM(result_MEM), .rd_MEM(rd_MEM),
        .regfile_we_MEM(regfile_we_MEM), .mem_fault_MEM(mem_fault_MEM)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected observable state for the current cycle.
    bit          chk_on = 0;
    bit          e_stall, e_req, e_dwe, e_valid, e_we, e_fault, e_chk_result, e_chk_rd;
    logic [31:0] e_addr, e_wdata, e_result;
    logic [3:0]  e_wstrb, e_rd;
    logic [31:0] seen_addr, seen_wdata;
    logic [3:0]  seen_wstrb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: access size in bytes, 0 for undefined encodings.
    function automatic int acc_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic bit m_fault(input logic [2:0] f3, input logic [31:0] a);
        int s = acc_size(f3);
        if (s == 0) return 1;
        return (a % s) != 0;
    endfunction

    function automatic logic [3:0] m_strobe(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] s = 0;
        int o = int'(a % 4);
        for (int i = 0; i < 4; i++)
            s[i] = (i >= o) && (i < o + acc_size(f3));
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        int s = acc_size(f3);
        if (s == 4) return d;
        for (int i = 0; i < 4; i++)
            w[8*i +: 8] = d[8*(i % s) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rdata);
        longint v;
        longint n;
        if (acc_size(f3) == 4) return rdata;
        n = 8 * acc_size(f3);
        v = (longint'(rdata) >> (8 * (a % 4))) % (longint'(1) << n);
        if (f3[2] == 1'b0 && v >= (longint'(1) << (n - 1)))
            v = v - (longint'(1) << n);
        return v[31:0];
    endfunction

    // Single compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("stall", {31'b0, stall}, {31'b0, e_stall});
            chk("dbus_req", {31'b0, dbus_req}, {31'b0, e_req});
            if (e_req) begin
                chk("dbus_addr", dbus_addr, e_addr);
                chk("dbus_we", {31'b0, dbus_we}, {31'b0, e_dwe});
                chk("dbus_wstrb", {28'b0, dbus_wstrb}, {28'b0, e_wstrb});
                if (e_dwe) chk("dbus_wdata", dbus_wdata, e_wdata);
            end
            chk("valid_MEM", {31'b0, valid_MEM}, {31'b0, e_valid});
            chk("regfile_we_MEM", {31'b0, regfile_we_MEM}, {31'b0, e_we});
            if (e_valid) begin
                chk("mem_fault_MEM", {31'b0, mem_fault_MEM}, {31'b0, e_fault});
                if (e_chk_result) chk("result_MEM", result_MEM, e_result);
                if (e_chk_rd) chk("rd_MEM", {28'b0, rd_MEM}, {28'b0, e_rd});
            end
        end
    end

    task automatic quiet_expect();
        e_stall = 0; e_req = 0; e_valid = 0; e_we = 0; e_fault = 0;
        e_chk_result = 0; e_chk_rd = 0;
    endtask

    // Present one instruction and play the bus; returns just after the completion edge.
    task automatic exec(input bit v, input bit ld, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd, input logic [3:0] rdi,
                        input bit we, input logic [31:0] rdata, input int gd, input int rvd);
        bit flt;
        valid_MEMPREP = v; mem_read_MEMPREP = ld; mem_write_MEMPREP = st;
        funct3_MEMPREP = f3; alu_result_MEMPREP = a; store_data_MEMPREP = sd;
        rd_MEMPREP = rdi; regfile_we_MEMPREP = we;
        @(posedge clk); #1;
        flt = (ld || st) && m_fault(f3, a);
        if (!(v && (ld || st)) || flt) begin
            e_stall = 0; e_req = 0; e_valid = v;
            e_we = v && we && !flt; e_fault = v && flt;
            e_result = a; e_chk_result = !flt; e_rd = rdi; e_chk_rd = !flt;
            return;
        end
        e_stall = 1; e_req = 1; e_valid = 0; e_we = 0; e_fault = 0;
        e_addr = {a[31:2], 2'b00}; e_dwe = st;
        e_wstrb = st ? m_strobe(f3, a) : 4'b0000;
        e_wdata = m_wdata(f3, sd);
        seen_addr = dbus_addr; seen_wdata = dbus_wdata; seen_wstrb = dbus_wstrb;
        // Upstream now changes freely; the captured op must not follow it.
        valid_MEMPREP = 0; alu_result_MEMPREP = ~a; rd_MEMPREP = ~rdi;
        funct3_MEMPREP = 3'b010; store_data_MEMPREP = ~sd;
        repeat (gd) begin @(posedge clk); #1; end
        dbus_gnt = 1;
        if (ld) begin dbus_rvalid = 1; dbus_rdata = 32'h5A5A_5A5A; end
        @(posedge clk); #1;
        dbus_gnt = 0; dbus_rvalid = 0; e_req = 0;
        if (st) begin
            e_stall = 0; e_valid = 1; e_we = 0; e_fault = 0;
            e_chk_result = 0; e_chk_rd = 0;
            return;
        end
        repeat (rvd - 1) begin @(posedge clk); #1; end
        dbus_rvalid = 1; dbus_rdata = rdata;
        @(posedge clk); #1;
        dbus_rvalid = 0;
        e_stall = 0; e_valid = 1; e_we = we; e_fault = 0;
        e_result = m_load(f3, a, rdata); e_chk_result = 1;
        e_rd = rdi; e_chk_rd = 1;
    endtask

    task automatic bubble();
        exec(0, 0, 0, 3'b000, 32'h0, 32'h0, 4'd0, 0, 32'h0, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        valid_MEMPREP = 0; mem_read_MEMPREP = 0; mem_write_MEMPREP = 0;
        funct3_MEMPREP = 0; alu_result_MEMPREP = 0; store_data_MEMPREP = 0;
        rd_MEMPREP = 0; regfile_we_MEMPREP = 0;
        dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", {31'b0, valid_MEM}, 32'd0);
        chk("reset_req", {31'b0, dbus_req}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_addr", dbus_addr, 32'd0);
        chk("reset_wstrb", {28'b0, dbus_wstrb}, 32'd0);
        chk("reset_result", result_MEM, 32'd0);
        rst = 0;
        quiet_expect();
        chk_on = 1;

        // Non-memory ALU op.
        exec(1, 0, 0, 3'b000, 32'h0000_1234, 32'h0, 4'd5, 1, 32'h0, 0, 1);
        chk("add_lit_result", result_MEM, 32'h0000_1234);
        chk("add_lit_we", {31'b0, regfile_we_MEM}, 32'd1);

        // SB with immediate grant.
        exec(1, 0, 1, 3'b000, 32'h0000_0103, 32'h0000_00AB, 4'd1, 0, 32'h0, 0, 1);
        chk("sb_lit_addr", seen_addr, 32'h0000_0100);
        chk("sb_lit_wstrb", {28'b0, seen_wstrb}, 32'h8);
        chk("sb_lit_wdata", seen_wdata, 32'hABAB_ABAB);

        // LB with delayed grant and late response.
        exec(1, 1, 0, 3'b000, 32'h0000_0202, 32'h0, 4'd7, 1, 32'h00F0_0000, 2, 3);
        chk("lb_lit", result_MEM, 32'hFFFF_FFF0);
        exec(1, 1, 0, 3'b100, 32'h0000_0202, 32'h0, 4'd8, 1, 32'h00F0_0000, 0, 1);
        chk("lbu_lit", result_MEM, 32'h0000_00F0);
        exec(1, 1, 0, 3'b001, 32'h0000_0202, 32'h0, 4'd9, 1, 32'h00F0_0000, 1, 2);
        chk("lh_lit", result_MEM, 32'h0000_00F0);
        exec(1, 1, 0, 3'b001, 32'h0000_0200, 32'h0, 4'd10, 1, 32'h1234_8765, 0, 1);
        chk("lh_neg_lit", result_MEM, 32'hFFFF_8765);
        exec(1, 1, 0, 3'b101, 32'h0000_0200, 32'h0, 4'd11, 1, 32'h1234_8765, 0, 1);
        exec(1, 1, 0, 3'b000, 32'h0000_0201, 32'h0, 4'd12, 1, 32'h0000_8000, 0, 2);
        chk("lb_b1_lit", result_MEM, 32'hFFFF_FF80);
        exec(1, 1, 0, 3'b010, 32'h0000_0300, 32'h0, 4'd13, 0, 32'hDEAD_BEEF, 1, 1);

        // SH / SW.
        exec(1, 0, 1, 3'b001, 32'h0000_0102, 32'h1234_CAFE, 4'd2, 0, 32'h0, 0, 1);
        chk("sh_lit_wstrb", {28'b0, seen_wstrb}, 32'hC);
        chk("sh_lit_wdata", seen_wdata, 32'hCAFE_CAFE);
        exec(1, 0, 1, 3'b010, 32'h0000_0104, 32'h89AB_CDEF, 4'd3, 0, 32'h0, 1, 1);
        exec(1, 0, 1, 3'b000, 32'h0000_0101, 32'h0000_0077, 4'd3, 0, 32'h0, 3, 1);

        // Faults.
        exec(1, 1, 0, 3'b010, 32'h0000_0301, 32'h0, 4'd4, 1, 32'h0, 0, 1);
        chk("lw_fault_lit", {31'b0, mem_fault_MEM}, 32'd1);
        exec(1, 1, 0, 3'b011, 32'h0000_0300, 32'h0, 4'd4, 1, 32'h0, 0, 1);
        chk("f3_011_fault_lit", {31'b0, mem_fault_MEM}, 32'd1);
        exec(1, 1, 0, 3'b001, 32'h0000_0201, 32'h0, 4'd4, 1, 32'h0, 0, 1);
        exec(1, 0, 1, 3'b010, 32'h0000_0302, 32'h1, 4'd4, 0, 32'h0, 0, 1);
        exec(1, 0, 0, 3'b111, 32'h0000_0055, 32'h0, 4'd6, 1, 32'h0, 0, 1);

        // Bubble with stale write enable.
        exec(0, 0, 0, 3'b000, 32'h0000_9999, 32'h0, 4'd5, 1, 32'h0, 0, 1);
        chk("bubble_lit_we", {31'b0, regfile_we_MEM}, 32'd0);
        bubble();

        // Reset in WAIT_RESP.
        valid_MEMPREP = 1; mem_read_MEMPREP = 1; mem_write_MEMPREP = 0;
        funct3_MEMPREP = 3'b010; alu_result_MEMPREP = 32'h0000_0400; rd_MEMPREP = 4'd9;
        regfile_we_MEMPREP = 1;
        @(posedge clk); #1;
        e_stall = 1; e_req = 1; e_valid = 0; e_we = 0; e_addr = 32'h0000_0400;
        e_dwe = 0; e_wstrb = 4'b0000;
        valid_MEMPREP = 0; mem_read_MEMPREP = 0; alu_result_MEMPREP = 0; rd_MEMPREP = 0;
        regfile_we_MEMPREP = 0;
        dbus_gnt = 1;
        @(posedge clk); #1;
        dbus_gnt = 0; e_req = 0;
        #2;
        rst = 1;
        quiet_expect();
        #1;
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_req", {31'b0, dbus_req}, 32'd0);
        chk("rst_mid_addr", dbus_addr, 32'd0);
        chk("rst_mid_valid", {31'b0, valid_MEM}, 32'd0);
        @(posedge clk); #1;
        rst = 0;
        dbus_rvalid = 1; dbus_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        dbus_rvalid = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_late_rvalid", {31'b0, valid_MEM}, 32'd0);

        // Back to normal operation after reset.
        exec(1, 1, 0, 3'b100, 32'h0000_0503, 32'h0, 4'd14, 1, 32'h7F00_0000, 0, 1);
        chk("post_rst_lbu_lit", result_MEM, 32'h0000_007F);
        bubble();
        @(posedge clk); #1;
        chk_on = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
